punct_conv_encoder: RTL and testbench

PUNCT_CONV_ENCODER -- requirements
Module: punct_conv_encoder

---
 rtl/punct_conv_encoder_pkg.sv | 15 +
 rtl/punct_conv_encoder_conv_parity.sv | 37 +++
 rtl/punct_conv_encoder.sv | 190 +++++++++++++++++++
 tb/tb_punct_conv_encoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/punct_conv_encoder_pkg.sv
// Shared defaults and FSM state encoding for the punctured convolutional encoder.
package punct_conv_encoder_pkg;

    localparam int MAX_K_DEF     = 9;
    localparam int MAX_N_DEF     = 4;
    localparam int PUNCT_LEN_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } enc_state_t;

endpackage

// File: rtl/punct_conv_encoder_conv_parity.sv
// Combinational generator parities: for each active generator j, XOR of the
// polynomial taps over the current bit and the K-1 most recent history bits.
module conv_parity
    import punct_conv_encoder_pkg::*;
#(
    parameter int MAX_K = MAX_K_DEF,
    parameter int MAX_N = MAX_N_DEF
) (
    input  logic                   bit_in,
    input  logic [MAX_K-2:0]       hist,        // hist[0] is the newest stored bit
    input  logic [3:0]             constr_len,
    input  logic [2:0]             code_rate,
    input  logic [MAX_N*MAX_K-1:0] gen_poly,
    output logic [MAX_N-1:0]       parity
);

    logic [MAX_K-1:0] taps_s;

    // taps_s[d] is the bit delayed by d cycles (d=0 is the bit being encoded)
    assign taps_s = {hist, bit_in};

    // Polynomial bit K-1-d multiplies the bit delayed by d; inactive generators read 0
    always_comb begin
        parity = {MAX_N{1'b0}};
        for (int j = 0; j < MAX_N; j++) begin
            for (int d = 0; d < MAX_K; d++) begin
                if ((j < int'(code_rate)) && (d < int'(constr_len))) begin
                    parity[j] = parity[j] ^
                        (gen_poly[j*MAX_K + int'(constr_len) - 1 - d] & taps_s[d]);
                end else begin
                    parity[j] = parity[j];
                end
            end
        end
    end

endmodule

// File: rtl/punct_conv_encoder.sv
// Rate-1/N convolutional encoder with zero-tail termination, optional
// puncturing and a single registered output slot with pass-through backpressure.
module punct_conv_encoder
    import punct_conv_encoder_pkg::*;
#(
    parameter int MAX_K     = MAX_K_DEF,
    parameter int MAX_N     = MAX_N_DEF,
    parameter int FRAME_W   = 16,
    parameter int PUNCT_LEN = PUNCT_LEN_DEF
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [2:0]                 i_code_rate,
    input  logic [3:0]                 i_constr_len,
    input  logic [MAX_N*MAX_K-1:0]     i_gen_poly,
    input  logic [FRAME_W-1:0]         i_frame_len,
    input  logic                       i_punct_en,
    input  logic [MAX_N*PUNCT_LEN-1:0] i_punct_pat,
    input  logic [3:0]                 i_punct_period,
    input  logic                       i_bit,
    input  logic                       i_bit_valid,
    output logic                       o_bit_ready,
    output logic [MAX_N-1:0]           o_sym,
    output logic [MAX_N-1:0]           o_sym_mask,
    output logic                       o_sym_valid,
    input  logic                       i_sym_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    enc_state_t                 state_r, next_state_s;
    logic [2:0]                 code_rate_r;
    logic [3:0]                 constr_len_r;
    logic [MAX_N*MAX_K-1:0]     gen_poly_r;
    logic [FRAME_W-1:0]         frame_len_r;
    logic                       punct_en_r;
    logic [MAX_N*PUNCT_LEN-1:0] punct_pat_r;
    logic [3:0]                 punct_period_r;
    logic [MAX_K-2:0]           hist_r;
    logic [FRAME_W-1:0]         bit_cnt_r;
    logic [3:0]                 tail_cnt_r;
    logic [3:0]                 phase_r;
    logic [MAX_N-1:0]           sym_r, mask_r;
    logic                       valid_r, done_r, err_r;

    logic                       slot_free_s, accept_s, load_s, enc_bit_s, cfg_ok_s;
    logic [MAX_N-1:0]           parity_s, mask_s;

    // The output slot can take a new symbol when empty or being drained this cycle
    assign slot_free_s = !valid_r || i_sym_ready;
    assign accept_s    = (state_r == ST_DATA) && i_bit_valid && slot_free_s;
    assign load_s      = accept_s || ((state_r == ST_TAIL) && slot_free_s);
    assign enc_bit_s   = (state_r == ST_DATA) ? i_bit : 1'b0;

    // Configuration legality; the period only matters when puncturing is on
    assign cfg_ok_s = (i_code_rate >= 3'd2) && (int'(i_code_rate) <= MAX_N) &&
                      (i_constr_len >= 4'd3) && (int'(i_constr_len) <= MAX_K) &&
                      (i_frame_len != {FRAME_W{1'b0}}) &&
                      (!i_punct_en || ((i_punct_period != 4'd0) &&
                                       (int'(i_punct_period) <= PUNCT_LEN)));

    conv_parity #(
        .MAX_K (MAX_K),
        .MAX_N (MAX_N)
    ) u_parity (
        .bit_in     (enc_bit_s),
        .hist       (hist_r),
        .constr_len (constr_len_r),
        .code_rate  (code_rate_r),
        .gen_poly   (gen_poly_r),
        .parity     (parity_s)
    );

    // Keep mask for the symbol being generated at the current puncture phase
    always_comb begin
        mask_s = {MAX_N{1'b0}};
        for (int j = 0; j < MAX_N; j++) begin
            if (j < int'(code_rate_r)) begin
                if (punct_en_r) begin
                    mask_s[j] = punct_pat_r[j*PUNCT_LEN + int'(phase_r)];
                end else begin
                    mask_s[j] = 1'b1;
                end
            end else begin
                mask_s[j] = 1'b0;
            end
        end
    end

    // Frame sequencing: data bits, then K-1 tail bits, then a one-cycle DONE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start && cfg_ok_s) next_state_s = ST_DATA;
                else                     next_state_s = ST_IDLE;
            end
            ST_DATA: begin
                if (accept_s && (bit_cnt_r == frame_len_r - FRAME_W'(1))) next_state_s = ST_TAIL;
                else                                                      next_state_s = ST_DATA;
            end
            ST_TAIL: begin
                if (slot_free_s && (tail_cnt_r == constr_len_r - 4'd2)) next_state_s = ST_DONE;
                else                                                    next_state_s = ST_TAIL;
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= next_state_s;
    end

    // Configuration latch, shift history, counters, phase and the output slot
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            code_rate_r    <= 3'd0;
            constr_len_r   <= 4'd0;
            gen_poly_r     <= {(MAX_N*MAX_K){1'b0}};
            frame_len_r    <= {FRAME_W{1'b0}};
            punct_en_r     <= 1'b0;
            punct_pat_r    <= {(MAX_N*PUNCT_LEN){1'b0}};
            punct_period_r <= 4'd0;
            hist_r         <= {(MAX_K-1){1'b0}};
            bit_cnt_r      <= {FRAME_W{1'b0}};
            tail_cnt_r     <= 4'd0;
            phase_r        <= 4'd0;
            sym_r          <= {MAX_N{1'b0}};
            mask_r         <= {MAX_N{1'b0}};
            valid_r        <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start && cfg_ok_s) begin
                        code_rate_r    <= i_code_rate;
                        constr_len_r   <= i_constr_len;
                        gen_poly_r     <= i_gen_poly;
                        frame_len_r    <= i_frame_len;
                        punct_en_r     <= i_punct_en;
                        punct_pat_r    <= i_punct_pat;
                        punct_period_r <= i_punct_period;
                        hist_r         <= {(MAX_K-1){1'b0}};
                        bit_cnt_r      <= {FRAME_W{1'b0}};
                        tail_cnt_r     <= 4'd0;
                        phase_r        <= 4'd0;
                    end else if (i_start) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= 1'b0;
                    end
                end
                ST_DONE: done_r <= 1'b1;
                default: done_r <= 1'b0;
            endcase

            if (load_s) begin
                hist_r  <= {hist_r[MAX_K-3:0], enc_bit_s};
                sym_r   <= parity_s;
                mask_r  <= mask_s;
                valid_r <= |mask_s;
                if (punct_en_r && (phase_r != punct_period_r - 4'd1)) phase_r <= phase_r + 4'd1;
                else                                                   phase_r <= 4'd0;
                if (state_r == ST_DATA) bit_cnt_r  <= bit_cnt_r + FRAME_W'(1);
                else                    tail_cnt_r <= tail_cnt_r + 4'd1;
            end else if (i_sym_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign o_bit_ready = (state_r == ST_DATA) && slot_free_s;
    assign o_sym       = sym_r;
    assign o_sym_mask  = mask_r;
    assign o_sym_valid = valid_r;
    assign o_busy      = (state_r != ST_IDLE);
    assign o_done      = done_r;
    assign o_err       = err_r;

endmodule

// File: tb/tb_punct_conv_encoder.sv
// Self-checking bench: a direct convolution model predicts every presented
// symbol; literal vectors pin the model for the hand-worked frames.
module tb_punct_conv_encoder;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [2:0]  i_code_rate = 3'd0;
    logic [3:0]  i_constr_len = 4'd0;
    logic [35:0] i_gen_poly = 36'd0;
    logic [15:0] i_frame_len = 16'd0;
    logic        i_punct_en = 1'b0;
    logic [31:0] i_punct_pat = 32'd0;
    logic [3:0]  i_punct_period = 4'd0;
    logic        i_bit = 1'b0;
    logic        i_bit_valid = 1'b0;
    logic        o_bit_ready;
    logic [3:0]  o_sym, o_sym_mask;
    logic        o_sym_valid;
    logic        i_sym_ready = 1'b1;
    logic        o_busy, o_done, o_err;

    punct_conv_encoder dut (
        .sys_clk(sys_clk), .rst(rst), .i_start(i_start), .i_code_rate(i_code_rate),
        .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_frame_len(i_frame_len),
        .i_punct_en(i_punct_en), .i_punct_pat(i_punct_pat), .i_punct_period(i_punct_period),
        .i_bit(i_bit), .i_bit_valid(i_bit_valid), .o_bit_ready(o_bit_ready),
        .o_sym(o_sym), .o_sym_mask(o_sym_mask), .o_sym_valid(o_sym_valid),
        .i_sym_ready(i_sym_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int last_sym_cyc = 0;
    int done_cyc = 0;
    logic toggle_ready = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [63:0] data_bits;
    int flen;

    localparam logic [35:0] POLY_K3 = {9'd0, 9'd0, 9'b101, 9'b111};
    localparam logic [35:0] POLY_K9 = {9'h1D9, 9'h165, 9'h0F3, 9'h1AF};
    localparam logic [35:0] POLY_K5 = {9'd0, 9'h019, 9'h01B, 9'h017};

    initial forever #5 sys_clk = ~sys_clk;
    initial forever begin @(posedge sys_clk); cyc++; end

    // Output-ready driver: held high or toggling every cycle
    initial forever begin
        @(posedge sys_clk);
        #1;
        if (toggle_ready) i_sym_ready = ~i_sym_ready;
        else              i_sym_ready = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected symbols by direct convolution over data followed by K-1 zeros
    task automatic build_exp(input int n, input int k, input logic [35:0] poly,
                             input logic pen, input logic [31:0] pat, input int per);
        exp_q.delete();
        got_q.delete();
        for (int t = 0; t < flen + k - 1; t++) begin
            logic [3:0] s;
            logic [3:0] m;
            s = 4'd0;
            m = 4'd0;
            for (int j = 0; j < n; j++) begin
                logic g;
                g = 1'b0;
                for (int d = 0; d < k; d++)
                    if ((t - d >= 0) && (t - d < flen)) g = g ^ (poly[j*9 + k - 1 - d] & data_bits[t - d]);
                s[j] = g;
                m[j] = pen ? pat[j*8 + (t % per)] : 1'b1;
            end
            if (m != 4'd0) exp_q.push_back({s, m});
        end
    endtask

    // Compare process: every transfer, hold-while-stalled, and bit_ready under stall
    initial begin
        logic       stall_prev;
        logic [7:0] stall_val;
        stall_prev = 1'b0;
        stall_val = 8'd0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                if (stall_prev) begin
                    check("hold_valid", {31'd0, o_sym_valid}, 32'd1);
                    check("hold_sym", {24'd0, o_sym, o_sym_mask}, {24'd0, stall_val});
                end
                if (o_sym_valid && !i_sym_ready) check("stall_bit_ready", {31'd0, o_bit_ready}, 32'd0);
                if (o_sym_valid && i_sym_ready) begin
                    got_q.push_back({o_sym, o_sym_mask});
                    last_sym_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_sym: got %0h expected none", {o_sym, o_sym_mask});
                    end else begin
                        check("sym", {24'd0, o_sym, o_sym_mask}, {24'd0, exp_q.pop_front()});
                    end
                end
                stall_prev = o_sym_valid && !i_sym_ready;
                stall_val = {o_sym, o_sym_mask};
                if (o_done) begin done_cnt++; done_cyc = cyc; end
                if (o_err) err_cnt++;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Start a frame, stream its bits, then wait for done and drain (or abort early)
    task automatic run_frame(input int n, input int k, input logic [35:0] poly, input logic pen,
                             input logic [31:0] pat, input int per, input int abort_after);
        int guard;
        logic acc;
        build_exp(n, k, poly, pen, pat, per);
        done_cnt = 0;
        @(posedge sys_clk); #1;
        i_code_rate = 3'(n); i_constr_len = 4'(k); i_gen_poly = poly; i_frame_len = 16'(flen);
        i_punct_en = pen; i_punct_pat = pat; i_punct_period = 4'(per); i_start = 1'b1;
        @(posedge sys_clk); #1;
        i_start = 1'b0;
        i_code_rate = 3'd7; i_constr_len = 4'd15; i_gen_poly = ~poly; i_frame_len = 16'd1;
        for (int b = 0; b < flen; b++) begin
            if (b == abort_after) return;
            i_bit = data_bits[b];
            i_bit_valid = 1'b1;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge sys_clk);
                acc = o_bit_ready;
                @(posedge sys_clk); #1;
                guard++;
            end
            if (!acc) begin
                check("bit_accept_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        i_bit_valid = 1'b0;
        guard = 0;
        while (done_cnt == 0 && guard < 400) begin @(posedge sys_clk); #1; guard++; end
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin @(posedge sys_clk); #1; guard++; end
        repeat (4) @(posedge sys_clk);
        #1;
        check("syms_left", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("idle_after", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic check_lit6(input string name, input logic [47:0] lit);
        check({name, "_size"}, 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < got_q.size()) check(name, {24'd0, got_q[i]}, {24'd0, lit[47 - 8*i -: 8]});
    endtask

    task automatic err_case(input string name, input logic [2:0] n, input logic [3:0] k,
                            input logic [15:0] fl, input logic pen, input logic [3:0] per);
        int e0;
        e0 = err_cnt;
        @(posedge sys_clk); #1;
        i_code_rate = n; i_constr_len = k; i_gen_poly = POLY_K3; i_frame_len = fl;
        i_punct_en = pen; i_punct_pat = 32'h0000_0103; i_punct_period = per; i_start = 1'b1;
        @(posedge sys_clk); #1;
        i_start = 1'b0;
        check({name, "_err_now"}, {31'd0, o_err}, 32'd1);
        check({name, "_busy"}, {31'd0, o_busy}, 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        check({name, "_err_pulses"}, 32'(err_cnt - e0), 32'd1);
        check({name, "_busy_later"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_outputs", {20'd0, o_bit_ready, o_sym, o_sym_mask, o_sym_valid, o_busy, o_done, o_err}, 32'd0);
        rst = 1'b1;

        // Hand-worked K=3 frame, ready held high; bits listed first-in at index 0
        flen = 4; data_bits = 64'b1101;
        run_frame(2, 3, POLY_K3, 1'b0, 32'd0, 1, -1);
        check_lit6("k3_plain", 48'h33_13_03_23_23_33);
        check("done_latency", 32'(done_cyc - last_sym_cyc), 32'd1);

        // Same frame with ready toggling
        toggle_ready = 1'b1;
        run_frame(2, 3, POLY_K3, 1'b0, 32'd0, 1, -1);
        check_lit6("k3_toggle", 48'h33_13_03_23_23_33);
        toggle_ready = 1'b0;

        // Same frame punctured, P=2: phase0 keeps both, phase1 keeps g0 only
        run_frame(2, 3, POLY_K3, 1'b1, 32'h0000_0103, 2, -1);
        check_lit6("k3_punct", 48'h33_11_03_21_23_31);

        // Illegal configurations
        err_case("rate5", 3'd5, 4'd3, 16'd4, 1'b0, 4'd0);
        err_case("k2", 3'd2, 4'd2, 16'd4, 1'b0, 4'd0);
        err_case("len0", 3'd2, 4'd3, 16'd0, 1'b0, 4'd0);
        err_case("period0", 3'd2, 4'd3, 16'd4, 1'b1, 4'd0);

        // Abort by reset after two accepted bits
        run_frame(2, 3, POLY_K3, 1'b0, 32'd0, 1, 2);
        rst = 1'b0;
        #1;
        check("abort_outputs", {20'd0, o_bit_ready, o_sym, o_sym_mask, o_sym_valid, o_busy, o_done, o_err}, 32'd0);
        i_bit_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", {31'd0, o_busy}, 32'd0);
        run_frame(2, 3, POLY_K3, 1'b0, 32'd0, 1, -1);
        check_lit6("k3_after_rst", 48'h33_13_03_23_23_33);

        // K=9, N=4, single bit: first symbol carries the polynomial MSBs
        flen = 1; data_bits = 64'b1;
        run_frame(4, 9, POLY_K9, 1'b0, 32'd0, 1, -1);
        check("k9_count", 32'(got_q.size()), 32'd9);
        if (got_q.size() > 0) check("k9_first", {24'd0, got_q[0]}, 32'h0000_00DF);

        // K=5, N=3, P=3 with an all-dropped phase, ready toggling
        toggle_ready = 1'b1;
        flen = 10; data_bits = 64'b0111001011;
        run_frame(3, 5, POLY_K5, 1'b1, 32'h0000_0103, 3, -1);
        check("k5_count", 32'(got_q.size()), 32'd10);
        toggle_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
